// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester, write-back and SRAM signal bundle for sram_arbiter
interface sram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_grant;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_grant;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_ren;
    logic              sram_wen;
    logic [DATA_W-1:0] sram_rdata;
    logic              busy;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_rdata,
        output rd_grant, rd_valid, rd_data, wr_grant,
               sram_addr, sram_wdata, sram_ren, sram_wen, busy
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_rdata,
        input  rd_grant, rd_valid, rd_data, wr_grant,
               sram_addr, sram_wdata, sram_ren, sram_wen, busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin read/write arbiter and read-latency sequencer for one SRAM port
module sram_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    sram_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, RD, RD_WAIT, WR} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(READ_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              prio_rd_q, prio_rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_valid_q, rd_valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prio_rd_q  <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prio_rd_q  <= prio_rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prio_rd_d  = prio_rd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Read wins when it is alone or when it holds the round-robin token.
                if (bus.rd_req && (!bus.wr_req || prio_rd_q)) begin
                    state_d = RD;
                    addr_d  = bus.rd_addr;
                end else if (bus.wr_req) begin
                    state_d = WR;
                    addr_d  = bus.wr_addr;
                    wdata_d = bus.wr_data;
                end
            end
            RD: begin
                cnt_d     = WAIT_LOAD;
                prio_rd_d = 1'b0;
                state_d   = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d    = bus.sram_rdata;
                    rd_valid_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR: begin
                prio_rd_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Enables, grants and busy are decodes of the state register only.
    assign bus.sram_ren   = (state_q == RD);
    assign bus.rd_grant   = (state_q == RD);
    assign bus.sram_wen   = (state_q == WR);
    assign bus.wr_grant   = (state_q == WR);
    assign bus.busy       = (state_q != IDLE);
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.rd_data    = rdata_q;
    assign bus.rd_valid   = rd_valid_q;
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter and sequencer for the single-port pixel SRAM in the edge-detector pipeline. It shares the SRAM between the pixel-fetch read port and the result write-back port. It sequences each read through the SRAM's fixed read latency and returns the read data with a valid pulse. Round-robin priority guarantees that neither stage starves while the pipeline streams.

## Interface
Parameters:
- ADDR_W, 16, SRAM address width
- DATA_W, 8, SRAM data width (pixel)
- READ_LAT, 2, cycles from sram_ren high to valid sram_rdata; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- rd_req  in  1  read request (level); hold until rd_grant
- rd_addr  in  ADDR_W  read address; stable while rd_req high
- rd_grant  out  1  one-cycle pulse: read issued to SRAM
- rd_valid  out  1  one-cycle pulse: rd_data valid
- rd_data  out  DATA_W  captured read data; holds until next rd_valid
- wr_req  in  1  write request (level); hold until wr_grant
- wr_addr  in  ADDR_W  write address; stable while wr_req high
- wr_data  in  DATA_W  write data; stable while wr_req high
- wr_grant  out  1  one-cycle pulse: write issued to SRAM
- sram_addr  out  ADDR_W  SRAM address (registered)
- sram_wdata  out  DATA_W  SRAM write data (registered)
- sram_ren  out  1  SRAM read enable (registered)
- sram_wen  out  1  SRAM write enable (registered)
- sram_rdata  in  DATA_W  SRAM read data
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, RD (issue), RD_WAIT, WR (issue).
- **IDLE**
  - Samples rd_req and wr_req at each clock edge. Requests are ignored in all other states.
  - Only rd_req: go to RD; load sram_addr from rd_addr.
  - Only wr_req: go to WR; load sram_addr from wr_addr and sram_wdata from wr_data.
  - Both: grant the side that was not granted last, as held in the priority bit prio_rd. prio_rd is 1 after reset, so read wins the first conflict.
  - Neither: stay in IDLE.
- **RD** (1 cycle)
  - sram_ren=1 and rd_grant=1.
  - Load the wait counter with READ_LAT-1, then go to RD_WAIT.
  - Clear prio_rd.
- **RD_WAIT**
  - sram_ren=0. Decrement the counter each cycle.
  - At the edge where the counter is 0, capture sram_rdata into rd_data, set rd_valid for the next cycle, and go to IDLE.
- **WR** (1 cycle)
  - sram_wen=1 and wr_grant=1.
  - Set prio_rd, then go to IDLE.
- sram_ren and sram_wen are never high in the same cycle.
- sram_addr and sram_wdata hold their last values while idle.
- A request still high in the IDLE cycle after its grant counts as a new request. Requesters must drop req, or present the next address/data, in the cycle after the grant.
- Reset, including mid-transaction:
  - State returns to IDLE and prio_rd to 1.
  - All outputs go to 0 immediately: sram_addr, sram_wdata, rd_data, all enables, grants, rd_valid and busy.
  - An in-flight read is discarded and produces no rd_valid.

## Timing
- Request sampled at the edge ending cycle 0; the issue state (RD or WR) occupies cycle 1.
- Read:
  - rd_grant and sram_ren high in cycle 1.
  - sram_rdata is sampled at the end of cycle READ_LAT+1.
  - rd_valid is high in cycle READ_LAT+2, which is also an IDLE cycle.
  - Back-to-back reads: one per READ_LAT+2 cycles.
- Write:
  - wr_grant and sram_wen high in cycle 1; IDLE in cycle 2.
  - Back-to-back writes: one per 2 cycles.
- busy is high in the RD, RD_WAIT and WR cycles, and low in the rd_valid cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset values:** assert rst mid-run → every output is 0 within the same cycle, with no clock needed.
- **Single read, READ_LAT=2:**
  - Stimulus: rd_req=1, rd_addr=0x0123 at cycle 0; SRAM model returns 0xA5 for that address.
  - Required: rd_grant and sram_ren in cycle 1, sram_addr=0x0123, rd_valid with rd_data=0xA5 in cycle 4, busy high in cycles 1-3.
- **Single write:**
  - Stimulus: wr_req=1, wr_addr=0x00FF, wr_data=0x3C.
  - Required: cycle 1 shows sram_wen=1, sram_addr=0x00FF, sram_wdata=0x3C and wr_grant=1; busy low in cycle 2.
- **Conflict round-robin:**
  - Stimulus: rd_req and wr_req held high continuously from reset, each dropped only for one cycle after its grant.
  - Required: grant order is read, write, read, write; sram_ren and sram_wen are never coincident.
- **Reset during RD_WAIT:** assert rst in cycle 2 of a read → rd_valid is never asserted; after release, a write completes normally.
- **Latency sweep:** repeat the single-read case with READ_LAT=1 and READ_LAT=5 → rd_valid arrives in cycle 3 and cycle 7 respectively, with correct data.
